// File: rtl/i2s_master.sv
// I2S master: BCK/LRCK generation, 32-bit frame TX serializer with a
// single-entry holding register, RX deserializer and sticky underrun flag.
module i2s_master #(
  parameter int BCK_DIV   = 6,
  parameter int SLOT_BITS = 16
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iEN,
  input  logic [SLOT_BITS-1:0] iTX_L,
  input  logic [SLOT_BITS-1:0] iTX_R,
  input  logic                 iTX_VALID,
  output logic                 oTX_READY,
  output logic                 oBCK,
  output logic                 oLRCK,
  output logic                 oADCDAT,
  input  logic                 iDACDAT,
  output logic [SLOT_BITS-1:0] oRX_L,
  output logic [SLOT_BITS-1:0] oRX_R,
  output logic                 oRX_VALID,
  output logic                 oUNDERRUN,
  input  logic                 iUNDERRUN_CLR
);

  localparam int FW = 2 * SLOT_BITS;
  localparam int CW = $clog2(FW);
  localparam logic [7:0]    DIV_TC = 8'(BCK_DIV - 1);
  localparam logic [CW-1:0] MID    = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] LAST   = CW'(FW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            bck_q, bck_d;
  logic            lrck_q, lrck_d;
  logic            dout_q, dout_d;
  logic [FW-1:0]   txsh_q, txsh_d;
  logic [FW-1:0]   rxsh_q, rxsh_d;
  logic [FW-1:0]   hold_q, hold_d;
  logic            full_q, full_d;
  logic [SLOT_BITS-1:0] rxl_q, rxl_d;
  logic [SLOT_BITS-1:0] rxr_q, rxr_d;
  logic            rxv_q, rxv_d;
  logic            und_q, und_d;

  logic          running, tc, rise, fall, wrap;
  logic          start, stop_now, load, und_set;
  logic [FW-1:0] rx_word;

  assign running  = (state_q != IDLE);
  assign tc       = (div_q == DIV_TC);
  assign rise     = running && tc && !bck_q;
  assign fall     = running && tc && bck_q;
  assign wrap     = fall && (cnt_q == LAST);
  assign start    = (state_q == IDLE) && iEN;
  assign stop_now = (state_q == STOP) && !iEN && wrap;
  assign load     = start || (wrap && !stop_now);
  // The final bit is taken at the closing edge, so a loopback lines up.
  assign rx_word  = {rxsh_q[FW-2:0], iDACDAT};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      bck_q   <= 1'b0;
      lrck_q  <= 1'b0;
      dout_q  <= 1'b0;
      txsh_q  <= '0;
      rxsh_q  <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      rxl_q   <= '0;
      rxr_q   <= '0;
      rxv_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bck_q   <= bck_d;
      lrck_q  <= lrck_d;
      dout_q  <= dout_d;
      txsh_q  <= txsh_d;
      rxsh_q  <= rxsh_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      rxl_q   <= rxl_d;
      rxr_q   <= rxr_d;
      rxv_q   <= rxv_d;
      und_q   <= und_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (iEN) state_d = RUN;
      RUN:  if (!iEN) state_d = STOP;
      STOP: begin
        if (iEN)       state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    bck_d   = bck_q;
    lrck_d  = lrck_q;
    dout_d  = dout_q;
    txsh_d  = txsh_q;
    rxsh_d  = rxsh_q;
    hold_d  = hold_q;
    full_d  = full_q;
    rxl_d   = rxl_q;
    rxr_d   = rxr_q;
    rxv_d   = 1'b0;
    und_set = 1'b0;

    if (start) begin
      div_d  = '0;
      cnt_d  = '0;
      bck_d  = 1'b0;
      lrck_d = 1'b1;
    end else if (running) begin
      div_d = tc ? 8'd0 : div_q + 8'd1;
      if (tc) bck_d = ~bck_q;
      if (rise) begin
        dout_d = txsh_q[FW-1];
        txsh_d = txsh_q << 1;
        rxsh_d = {rxsh_q[FW-2:0], iDACDAT};
      end
      if (fall) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == MID) lrck_d = 1'b0;
      end
      if (wrap) begin
        lrck_d = 1'b1;
        rxl_d  = rx_word[FW-1:SLOT_BITS];
        rxr_d  = rx_word[SLOT_BITS-1:0];
        rxv_d  = 1'b1;
      end
      if (stop_now) begin
        div_d  = '0;
        cnt_d  = '0;
        bck_d  = 1'b0;
        lrck_d = 1'b0;
        dout_d = 1'b0;
      end
    end

    if (load) begin
      if (full_q) begin
        txsh_d = hold_q;
        full_d = 1'b0;
      end else begin
        txsh_d  = '0;
        und_set = 1'b1;
      end
    end

    // An empty load still lets a same-cycle offer land in holding.
    if (iTX_VALID && !full_q) begin
      hold_d = {iTX_L, iTX_R};
      full_d = 1'b1;
    end

    und_d = und_set | (und_q & ~iUNDERRUN_CLR);
  end

  always_comb begin
    oTX_READY = ~full_q;
    oBCK      = bck_q;
    oLRCK     = lrck_q;
    oADCDAT   = dout_q;
    oRX_L     = rxl_q;
    oRX_R     = rxr_q;
    oRX_VALID = rxv_q;
    oUNDERRUN = und_q;
  end

endmodule

// File: doc/i2s_master.md
I2S_MASTER -- requirements
Module: i2s_master

Interface
REQ-001 Parameter BCK_DIV, default 6: iCLK cycles per BCK half-period; legal range 2..255. With an 18.432 MHz iCLK this gives a 48 kHz frame.
REQ-002 Parameter SLOT_BITS, fixed 16: bits per channel slot; a frame is 32 BCK periods.
REQ-003 iCLK  in  1  system clock; all logic is rising-edge iCLK.
REQ-004 iRST_N  in  1  reset, asynchronous, active-low.
REQ-005 iEN  in  1  run enable; sampled at frame boundaries.
REQ-006 iTX_L, iTX_R  in  16 each  next left and right sample to serialize.
REQ-007 iTX_VALID  in  1  parallel TX sample offered.
REQ-008 oTX_READY  out  1  holding register empty; a transfer occurs when iTX_VALID and oTX_READY are both high.
REQ-009 oBCK  out  1  generated bit clock.
REQ-010 oLRCK  out  1  frame clock; 1 = left slot, 0 = right slot.
REQ-011 oADCDAT  out  1  serial TX data, MSB first.
REQ-012 iDACDAT  in  1  serial RX data returned by the converter side.
REQ-013 oRX_L, oRX_R  out  16 each  last complete received frame.
REQ-014 oRX_VALID  out  1  one-iCLK pulse when oRX_L/oRX_R update.
REQ-015 oUNDERRUN  out  1  sticky flag: a frame started with the holding register empty.
REQ-016 iUNDERRUN_CLR  in  1  synchronous clear of oUNDERRUN.

Function
REQ-017 The FSM SHALL have three states:
- IDLE: oBCK=0, oLRCK=0, oADCDAT=0.
- RUN: IDLE->RUN when iEN=1.
- STOP: RUN->STOP when iEN=0 mid-frame.
REQ-018 On IDLE->RUN, in the same iCLK edge, the block SHALL:
- set oLRCK=1, bit counter=0, divider=0, oBCK=0;
- perform a frame load (REQ-022).
REQ-019 BCK generation: the divider SHALL count 0..BCK_DIV-1 and toggle oBCK on terminal count. BCK period = 2*BCK_DIV iCLK; frame = 64*BCK_DIV iCLK.
REQ-020 On each BCK rising strobe, the block SHALL:
- drive oADCDAT with shift-register MSB, then shift left;
- capture iDACDAT into the RX shift register (MSB first).
REQ-021 On each BCK falling strobe, the 5-bit counter SHALL increment. On 15->16, oLRCK SHALL go 0. On 31->0 (frame wrap), oLRCK SHALL go 1 and a frame load occurs.
REQ-022 Frame load, holding register full: the TX shift register SHALL take {L,R} (32 bits) and oTX_READY SHALL be 1 on the next cycle.
REQ-023 Frame load, holding register empty: the block SHALL load 32'h0 and set oUNDERRUN.
REQ-024 If iTX_VALID arrives in the same cycle as an empty load, zeros SHALL be sent and the new sample SHALL be captured into holding for the next frame.
REQ-025 Holding capture: on iTX_VALID&oTX_READY, the block SHALL latch iTX_L/iTX_R and drive oTX_READY=0 on the next cycle. A single-entry buffer only.
REQ-026 At each frame wrap, the block SHALL copy RX bits 31:16 to oRX_L and 15:0 to oRX_R and pulse oRX_VALID for exactly 1 iCLK.
REQ-027 If iEN=0 is seen in RUN, the state SHALL go to STOP. At the next frame wrap, REQ-026 SHALL still apply, then the state SHALL go to IDLE: oBCK=0, oLRCK=0, oADCDAT=0, no new load, holding preserved.
REQ-028 If iEN returns to 1 while in STOP, the state SHALL go back to RUN with no frame interruption.
REQ-029 Setting and clearing oUNDERRUN in the same cycle: set SHALL win.
REQ-030 oBCK, oLRCK and oADCDAT SHALL be registered outputs, glitch-free.

Reset
REQ-031 Asserting iRST_N low SHALL immediately produce: state IDLE, oBCK=0, oLRCK=0, oADCDAT=0, oTX_READY=1, oRX_L=oRX_R=0, oRX_VALID=0, oUNDERRUN=0, all counters and shift/holding registers 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no oRX_VALID pulse; after release, operation SHALL restart from IDLE.

Verification
REQ-033 BCK_DIV=6, iEN=1, TX L=16'hA5C3, R=16'h0F0F, preloaded -> oBCK period 12 iCLK; oLRCK high 16 BCK and low 16 BCK; oADCDAT at falling edges = A5C3 then 0F0F, MSB first.
REQ-034 iDACDAT looped to oADCDAT, L=16'h8001, R=16'h7FFE -> one frame later: oRX_L=8001, oRX_R=7FFE, oRX_VALID high exactly 1 cycle, coincident with oLRCK rising.
REQ-035 No iTX_VALID before the first frame -> oADCDAT all 0 for 32 bits; oUNDERRUN=1 until iUNDERRUN_CLR; holding a write at frame start -> zeros sent, the next frame carries the sample.
REQ-036 iEN dropped at bit 5 -> frame completes to bit 31; oRX_VALID pulses; then oBCK/oLRCK stay 0 and oTX_READY is unchanged.
REQ-037 iRST_N low at bit 20 -> all outputs at reset values within the same cycle, no oRX_VALID; after release with iEN=1 -> new frame starts with oLRCK=1.
REQ-038 BCK_DIV=2 back-to-back frames with iTX_VALID held high -> one transfer per frame, oTX_READY toggles once per frame, no underrun.
